game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//   Top-level game controller for Memory Matrix. Sequences one round:
//   start handshake, timed reveal of the solution board, then guess play.
//   Edge-detects the 8 tile buttons and scores each press against the
//   solution. Tracks the correctly revealed tiles and the remaining wrong
//   guesses. Declares win/lose and drives the 8-tile LED board.
//   Sits between the Board generator (solution source) and the LED/HEX outputs.
// PARAMETERS
//   DISPLAY_CYCLES  100000000  clk cycles the solution is shown (2 s @ 50 MHz); must be >= 1
//   GUESS_W         4          width of guess counters
// PORTS
//   clk            in   1        system clock (CLOCK_50)
//   reset          in   1        synchronous, active-high reset
//   start          in   1        debounced start button, level, active-high
//   solution_board in   8        solution from Board generator; sampled once per round
//   max_guesses    in   GUESS_W  wrong guesses allowed; sampled once per round
//   tile_btn       in   8        player tile buttons, level, active-high, bit i = tile i
//   new_game       out  1        1-cycle pulse asking Board generator for a new solution
//   board_led      out  8        LED board pattern
//   guesses_left   out  GUESS_W  remaining wrong guesses (to HEX0 decoder)
//   win            out  1        round won; held until next round starts
//   lose           out  1        round lost; held until next round starts
//   state_dbg      out  3        current FSM state encoding
// BEHAVIOUR
//   State encodings: IDLE=0, START_WAIT=1, DISPLAY=2, PLAY=3, CHECK=4, WIN=5, LOSE=6, END_WAIT=7.
//   Reset (sync, any state, including mid-round):
//     - state -> IDLE
//     - solution_reg, current_board, guesses_left, timer, btn_q, guess_reg -> 0
//     - all outputs 0
//   IDLE: start=1 -> START_WAIT. new_game=1 in that same cycle only.
//   START_WAIT: stays while start=1. On start=0:
//     - solution_reg <= solution_board
//     - guesses_left <= max_guesses
//     - current_board <= 0
//     - win, lose <= 0
//     - timer <= DISPLAY_CYCLES-1
//     - -> DISPLAY
//   DISPLAY: timer counts down by 1 per cycle. When timer==0 -> PLAY.
//     DISPLAY therefore lasts exactly DISPLAY_CYCLES cycles.
//   PLAY:
//     - If current_board==solution_reg -> WIN. This takes priority and covers solution 0.
//     - Else press = tile_btn & ~btn_q, where btn_q is tile_btn registered every cycle in all states.
//     - If press!=0: guess_reg <= lowest set bit of press (one-hot) -> CHECK.
//       Other bits pressed in the same cycle are discarded.
//   CHECK (one cycle):
//     - hit  = |(guess_reg & solution_reg)
//     - dup  = |(guess_reg & current_board)
//     - hit: current_board <= current_board | guess_reg.
//       If (current_board|guess_reg)==solution_reg -> WIN, else -> PLAY.
//     - dup hit: no penalty, no change -> PLAY.
//     - miss, guesses_left<=1: guesses_left <= 0 -> LOSE.
//       max_guesses=0 therefore loses on the first miss.
//     - miss otherwise: guesses_left <= guesses_left-1 -> PLAY.
//     - Presses arriving during CHECK are ignored. btn_q still updates, so they are not replayed.
//   WIN: win=1. LOSE: lose=1.
//     - From either: start=1 -> END_WAIT.
//     - END_WAIT: stays while start=1; start=0 -> IDLE.
//     - win/lose hold through END_WAIT and IDLE; cleared in START_WAIT exit.
//   board_led:
//     - = solution_reg in DISPLAY and LOSE (reveal)
//     - = current_board in all other states
//     - 0 after reset
//     - Registered: the output reflects the state one cycle later.
//   guesses_left never underflows. It is never incremented within a round.
//   Inputs solution_board and max_guesses are don't-care outside START_WAIT exit.
// TESTING (bench uses DISPLAY_CYCLES=4, GUESS_W=4)
//   1. Reset, start 1 for 3 cycles then 0, sol=8'h81, max=3
//      -> new_game single pulse; board_led=8'h81 for exactly 4 cycles, then 8'h00; guesses_left=3.
//   2. In PLAY press tile0 then tile7 (separate edges)
//      -> board_led 8'h01 then 8'h81; win=1; guesses_left stays 3.
//   3. sol=8'h81, max=2; press tile1, tile2
//      -> guesses_left 2->1->0; lose=1; board_led=8'h81.
//   4. Press tile0 twice (release between), then hold tile0 8 cycles
//      -> current_board=8'h01, guesses_left unchanged, exactly one CHECK per edge.
//   5. tile_btn 0->8'h06 in one cycle, sol=8'h04
//      -> only tile1 scored (miss), guesses_left-1; tile2 not scored until re-pressed.
//   6. Assert reset mid-DISPLAY and mid-PLAY
//      -> next cycle state_dbg=0, board_led=0, win=lose=0, guesses_left=0; sol=8'h00 round goes straight to WIN after DISPLAY.

Source files
------------

// File: rtl/game_sequencer.sv
// Memory Matrix round controller: start handshake, timed solution reveal, edge-detected
// tile guessing with hit/miss scoring, win/lose declaration and LED board drive.
module game_sequencer #(
    parameter int unsigned DISPLAY_CYCLES = 100000000,
    parameter int unsigned GUESS_W        = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [7:0]         i_solution_board,
    input  logic [GUESS_W-1:0] i_max_guesses,
    input  logic [7:0]         i_tile_btn,
    output logic               o_new_game,
    output logic [7:0]         o_board_led,
    output logic [GUESS_W-1:0] o_guesses_left,
    output logic               o_win,
    output logic               o_lose,
    output logic [2:0]         o_state_dbg
);

    localparam int unsigned TIMER_W = (DISPLAY_CYCLES > 1) ? $clog2(DISPLAY_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DISPLAY_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStartWait = 3'd1,
        StDisplay   = 3'd2,
        StPlay      = 3'd3,
        StCheck     = 3'd4,
        StWin       = 3'd5,
        StLose      = 3'd6,
        StEndWait   = 3'd7
    } state_t;

    state_t               r_state;
    logic [7:0]           r_solution;
    logic [7:0]           r_current_board;
    logic [GUESS_W-1:0]   r_guesses_left;
    logic [TIMER_W-1:0]   r_timer;
    logic [7:0]           r_btn_q;
    logic [7:0]           r_guess;
    logic                 r_new_game;
    logic [7:0]           r_board_led;
    logic                 r_win;
    logic                 r_lose;

    logic [7:0] w_press;
    logic [7:0] w_press_low;
    logic [7:0] w_board_hit;
    logic       w_hit;
    logic       w_reveal;

    // Two's-complement trick isolates the lowest pressed tile; the rest are discarded.
    assign w_press     = i_tile_btn & ~r_btn_q;
    assign w_press_low = w_press & (~w_press + 8'd1);
    assign w_hit       = |(r_guess & r_solution);
    assign w_board_hit = r_current_board | r_guess;
    assign w_reveal    = (r_state == StDisplay) || (r_state == StLose);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= StIdle;
            r_solution      <= '0;
            r_current_board <= '0;
            r_guesses_left  <= '0;
            r_timer         <= '0;
            r_btn_q         <= '0;
            r_guess         <= '0;
            r_new_game      <= 1'b0;
            r_board_led     <= '0;
            r_win           <= 1'b0;
            r_lose          <= 1'b0;
        end else begin
            r_btn_q     <= i_tile_btn;
            r_new_game  <= 1'b0;
            r_board_led <= w_reveal ? r_solution : r_current_board;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_new_game <= 1'b1;
                        r_state    <= StStartWait;
                    end
                end
                StStartWait: begin
                    if (!i_start) begin
                        r_solution      <= i_solution_board;
                        r_guesses_left  <= i_max_guesses;
                        r_current_board <= '0;
                        r_win           <= 1'b0;
                        r_lose          <= 1'b0;
                        r_timer         <= TIMER_LOAD;
                        r_state         <= StDisplay;
                    end
                end
                StDisplay: begin
                    if (r_timer == '0) begin
                        r_state <= StPlay;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                StPlay: begin
                    if (r_current_board == r_solution) begin
                        r_win   <= 1'b1;
                        r_state <= StWin;
                    end else if (w_press != '0) begin
                        r_guess <= w_press_low;
                        r_state <= StCheck;
                    end
                end
                StCheck: begin
                    // A repeated hit leaves the board unchanged and, since the board
                    // differed from the solution in PLAY, falls back to PLAY unpenalised.
                    if (w_hit) begin
                        r_current_board <= w_board_hit;
                        if (w_board_hit == r_solution) begin
                            r_win   <= 1'b1;
                            r_state <= StWin;
                        end else begin
                            r_state <= StPlay;
                        end
                    end else if (r_guesses_left <= GUESS_W'(1)) begin
                        r_guesses_left <= '0;
                        r_lose         <= 1'b1;
                        r_state        <= StLose;
                    end else begin
                        r_guesses_left <= r_guesses_left - GUESS_W'(1);
                        r_state        <= StPlay;
                    end
                end
                StWin, StLose: begin
                    if (i_start) begin
                        r_state <= StEndWait;
                    end
                end
                StEndWait: begin
                    if (!i_start) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_new_game     = r_new_game;
    assign o_board_led    = r_board_led;
    assign o_guesses_left = r_guesses_left;
    assign o_win          = r_win;
    assign o_lose         = r_lose;
    assign o_state_dbg    = r_state;

endmodule
